// File: rtl/blur_line_ctrl_if.sv
// Handshake/config bundle between the video decoder/host and blur_line_ctrl.
interface blur_line_ctrl_if #(
    parameter int unsigned FILTER_SIZE = 11,
    parameter int unsigned COEFF_W     = 6,
    parameter int unsigned COL_W       = 10
);
    // Video timing and host configuration inputs
    logic [2:0]                     fvh_in;
    logic                           dv_in;
    logic                           cfg_we;
    logic [3:0]                     cfg_addr;
    logic [COEFF_W-1:0]             cfg_data;
    logic                           cfg_commit;

    // Sequencing and coefficient outputs toward the blur datapath
    logic [FILTER_SIZE*COEFF_W-1:0] coeffs;
    logic [9:0]                     coeff_sum;
    logic                           win_clear;
    logic                           px_ok;
    logic [COL_W-1:0]               col;
    logic [COL_W-1:0]               line;
    logic                           commit_pending;
    logic                           cfg_err;

    // Source side: decoder timing plus host config port
    modport master (
        output fvh_in, dv_in, cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  coeffs, coeff_sum, win_clear, px_ok, col, line,
               commit_pending, cfg_err
    );

    // Controller side
    modport slave (
        input  fvh_in, dv_in, cfg_we, cfg_addr, cfg_data, cfg_commit,
        output coeffs, coeff_sum, win_clear, px_ok, col, line,
               commit_pending, cfg_err
    );
endinterface

// File: rtl/blur_line_ctrl.sv
// Line-blur sequencer: tracks fvh/dv timing, flags full-window pixels with
// their column/line, and owns a double-buffered coefficient bank that swaps
// only at the start of vertical blank.
module blur_line_ctrl #(
    parameter int unsigned FILTER_SIZE = 11,
    parameter int unsigned COEFF_W     = 6,
    parameter int unsigned COL_W       = 10,
    parameter int unsigned RESET_COEFF = 23
) (
    input  logic            clk,
    input  logic            reset,
    blur_line_ctrl_if.slave bus
);
    localparam int unsigned BANK_W  = FILTER_SIZE * COEFF_W;
    localparam int unsigned SUM_W   = 10;
    localparam int unsigned MAX_SUM = 255;
    localparam int unsigned HALF    = (FILTER_SIZE - 1) / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HBLANK = 2'd1,
        WARMUP = 2'd2,
        ACTIVE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        fvh_q;
    logic [COL_W-1:0]  pc_q, pc_d, pc_inc_c;
    logic [COL_W-1:0]  line_q, line_d, line_inc_c;
    logic [COL_W-1:0]  col_q, col_d;
    logic              win_clear_q, win_clear_d;
    logic              px_ok_q, px_ok_d;
    logic              vb_rise_c, hb_rise_c;

    logic [BANK_W-1:0] shadow_q, shadow_d;
    logic [BANK_W-1:0] active_q, active_d;
    logic [SUM_W-1:0]  shadow_sum_c;
    logic [SUM_W-1:0]  coeff_sum_q, coeff_sum_d;
    logic              sum_ok_c;
    logic              pend_q, pend_d;
    logic              err_q, err_d;

    // Field bit is carried on the bus but plays no part in sequencing.
    logic              unused_field;
    assign unused_field = bus.fvh_in[2];

    // Blank rising edges relative to the previous sample
    assign vb_rise_c = bus.fvh_in[1] & ~fvh_q[1];
    assign hb_rise_c = bus.fvh_in[0] & ~fvh_q[0];

    // Saturating increments for pixel and line counters
    assign pc_inc_c   = (&pc_q)   ? pc_q   : pc_q + COL_W'(1);
    assign line_inc_c = (&line_q) ? line_q : line_q + COL_W'(1);

    // Next state, counters and datapath strobes
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        line_d      = line_q;
        col_d       = col_q;
        win_clear_d = 1'b0;
        px_ok_d     = 1'b0;

        if (vb_rise_c) begin
            // Start of vertical blank restarts the frame from any state
            state_d     = HBLANK;
            win_clear_d = 1'b1;
            pc_d        = '0;
            line_d      = '0;
        end else if (hb_rise_c && (state_q != IDLE)) begin
            state_d     = HBLANK;
            win_clear_d = 1'b1;
            pc_d        = '0;
            if ((state_q == WARMUP) || (state_q == ACTIVE)) begin
                line_d = line_inc_c;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HBLANK: begin
                    if (bus.dv_in && (bus.fvh_in[1:0] == 2'b00)) begin
                        pc_d    = pc_inc_c;
                        state_d = (pc_inc_c == COL_W'(FILTER_SIZE - 1)) ? ACTIVE : WARMUP;
                    end
                end
                WARMUP: begin
                    if (bus.dv_in) begin
                        pc_d    = pc_inc_c;
                        state_d = (pc_inc_c == COL_W'(FILTER_SIZE - 1)) ? ACTIVE : WARMUP;
                    end
                end
                ACTIVE: begin
                    if (bus.dv_in) begin
                        px_ok_d = 1'b1;
                        col_d   = pc_q - COL_W'(HALF);
                        pc_d    = pc_inc_c;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Timing state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fvh_q       <= 2'b00;
            pc_q        <= '0;
            line_q      <= '0;
            col_q       <= '0;
            win_clear_q <= 1'b0;
            px_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fvh_q       <= bus.fvh_in[1:0];
            pc_q        <= pc_d;
            line_q      <= line_d;
            col_q       <= col_d;
            win_clear_q <= win_clear_d;
            px_ok_q     <= px_ok_d;
        end
    end

    // Shadow bank with this cycle's host write folded in
    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
            if (bus.cfg_we && (bus.cfg_addr == 4'(i))) begin
                shadow_d[i*COEFF_W +: COEFF_W] = bus.cfg_data;
            end
        end
    end

    // Full-width sum of the updated shadow bank
    always_comb begin
        shadow_sum_c = '0;
        for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
            shadow_sum_c = shadow_sum_c + SUM_W'(shadow_d[i*COEFF_W +: COEFF_W]);
        end
    end

    assign sum_ok_c = (shadow_sum_c <= SUM_W'(MAX_SUM));

    // Commit check and vertical-blank bank transfer
    always_comb begin
        active_d    = active_q;
        coeff_sum_d = coeff_sum_q;
        pend_d      = pend_q;
        err_d       = err_q;

        if (bus.cfg_commit) begin
            if (sum_ok_c) begin
                pend_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // A legal commit on the blank edge itself transfers immediately
        if (vb_rise_c && pend_d) begin
            active_d    = shadow_d;
            coeff_sum_d = shadow_sum_c;
            pend_d      = 1'b0;
        end
    end

    // Coefficient bank registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= {FILTER_SIZE{COEFF_W'(RESET_COEFF)}};
            active_q    <= {FILTER_SIZE{COEFF_W'(RESET_COEFF)}};
            coeff_sum_q <= SUM_W'(FILTER_SIZE * RESET_COEFF);
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            coeff_sum_q <= coeff_sum_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

    assign bus.coeffs         = active_q;
    assign bus.coeff_sum      = coeff_sum_q;
    assign bus.win_clear      = win_clear_q;
    assign bus.px_ok          = px_ok_q;
    assign bus.col            = col_q;
    assign bus.line           = line_q;
    assign bus.commit_pending = pend_q;
    assign bus.cfg_err        = err_q;
endmodule

// File: tb/tb_blur_line_ctrl.sv
// Self-checking bench for blur_line_ctrl: directed vector table, corner-case
// sequences and random traffic against a frame/line-level reference model.
module tb_blur_line_ctrl;
    localparam int unsigned FS = 11;
    localparam int unsigned CW = 6;
    localparam int unsigned LW = 10;
    localparam int unsigned BW = FS * CW;
    localparam int          CMAX = 1023;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    blur_line_ctrl_if #(.FILTER_SIZE(FS), .COEFF_W(CW), .COL_W(LW)) bus ();

    blur_line_ctrl #(
        .FILTER_SIZE(FS), .COEFF_W(CW), .COL_W(LW), .RESET_COEFF(23)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame/line bookkeeping in plain integers
    logic [2:0] m_prev;
    bit         m_framed, m_in_line, m_wc, m_px, m_pend, m_err;
    int         m_npix, m_line, m_col, m_sum;
    int         m_sh [FS];
    int         m_act[FS];

    typedef struct packed {
        logic [2:0] fvh;
        logic       dv;
        logic       px;
        logic [9:0] col;
        logic [9:0] line;
        logic       wc;
    } vec_t;

    vec_t vt[26];

    function automatic vec_t mk(logic [2:0] f, logic d, logic p, int c, int l, logic w);
        vec_t v;
        v.fvh = f; v.dv = d; v.px = p; v.col = 10'(c); v.line = 10'(l); v.wc = w;
        return v;
    endfunction

    function automatic logic [BW-1:0] all_taps(int v);
        logic [BW-1:0] r;
        for (int i = 0; i < FS; i++) r[i*CW +: CW] = CW'(v);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 3'b000; m_framed = 0; m_in_line = 0; m_wc = 0; m_px = 0;
        m_npix = 0; m_line = 0; m_col = 0; m_pend = 0; m_err = 0;
        for (int i = 0; i < FS; i++) begin
            m_sh[i] = 23; m_act[i] = 23;
        end
        m_sum = FS * 23;
    endtask

    task automatic model_step(input logic [2:0] fvh, input logic dv, input logic we,
                              input logic [3:0] addr, input logic [5:0] data, input logic commit);
        bit vr, hr;
        int s;
        vr = fvh[1] & ~m_prev[1];
        hr = fvh[0] & ~m_prev[0];
        m_prev = fvh;
        m_wc = 0;
        m_px = 0;
        if (vr) begin
            m_framed = 1; m_in_line = 0; m_npix = 0; m_line = 0; m_wc = 1;
        end else if (hr && m_framed) begin
            if (m_in_line) m_line = (m_line == CMAX) ? CMAX : m_line + 1;
            m_in_line = 0; m_npix = 0; m_wc = 1;
        end else if (m_framed && dv && (m_in_line || fvh[1:0] == 2'b00)) begin
            // Pixel number m_npix (0-based) completes a window once FS pixels are in
            if (m_npix >= FS - 1) begin
                m_px = 1;
                m_col = m_npix - (FS - 1) / 2;
            end
            m_in_line = 1;
            m_npix = (m_npix == CMAX) ? CMAX : m_npix + 1;
        end
        if (we && addr < FS) m_sh[addr] = data;
        s = 0;
        for (int i = 0; i < FS; i++) s += m_sh[i];
        if (commit) begin
            if (s > 255) m_err = 1;
            else m_pend = 1;
        end
        if (vr && m_pend) begin
            for (int i = 0; i < FS; i++) m_act[i] = m_sh[i];
            m_sum = s;
            m_pend = 0;
        end
    endtask

    task automatic model_check();
        logic [BW-1:0] ec;
        for (int i = 0; i < FS; i++) ec[i*CW +: CW] = CW'(m_act[i]);
        chk("m_win_clear", bus.win_clear, m_wc);
        chk("m_px_ok", bus.px_ok, m_px);
        chk("m_col", bus.col, m_col);
        chk("m_line", bus.line, m_line);
        chk("m_pending", bus.commit_pending, m_pend);
        chk("m_cfg_err", bus.cfg_err, m_err);
        chk("m_coeffs", bus.coeffs, ec);
        chk("m_coeff_sum", bus.coeff_sum, m_sum);
    endtask

    // One clock: drive at negedge, model on posedge, compare at next negedge
    task automatic cycle(input logic rst, input logic [2:0] fvh, input logic dv, input logic we,
                         input logic [3:0] addr, input logic [5:0] data, input logic commit);
        reset = rst;
        bus.fvh_in = fvh; bus.dv_in = dv; bus.cfg_we = we;
        bus.cfg_addr = addr; bus.cfg_data = data; bus.cfg_commit = commit;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(fvh, dv, we, addr, data, commit);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic [BW-1:0] e;
        logic [2:0]    rfvh;
        logic [5:0]    rdata;

        // Directed vector table: pre-frame pixels, one line of 20 pixels, line advance
        vt[0] = mk(3'b000, 1, 0, 0, 0, 0);
        vt[1] = mk(3'b000, 1, 0, 0, 0, 0);
        vt[2] = mk(3'b011, 0, 0, 0, 0, 1);
        vt[3] = mk(3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            vt[4+i] = mk(3'b000, 1, (i >= 10), (i >= 10) ? i - 5 : 0, 0, 0);
        vt[24] = mk(3'b001, 0, 0, 14, 1, 1);
        vt[25] = mk(3'b000, 0, 0, 14, 1, 0);

        reset = 1'b1;
        bus.fvh_in = '0; bus.dv_in = 0; bus.cfg_we = 0;
        bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 0;
        model_reset();
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);

        chk("rst_coeffs", bus.coeffs, all_taps(23));
        chk("rst_sum", bus.coeff_sum, 253);
        chk("rst_wc", bus.win_clear, 0);
        chk("rst_px", bus.px_ok, 0);
        chk("rst_col", bus.col, 0);
        chk("rst_line", bus.line, 0);
        chk("rst_pend", bus.commit_pending, 0);
        chk("rst_err", bus.cfg_err, 0);

        for (int r = 0; r < 26; r++) begin
            cycle(0, vt[r].fvh, vt[r].dv, 0, 0, 0, 0);
            chk($sformatf("vec%0d_px", r), bus.px_ok, vt[r].px);
            chk($sformatf("vec%0d_col", r), bus.col, vt[r].col);
            chk($sformatf("vec%0d_line", r), bus.line, vt[r].line);
            chk($sformatf("vec%0d_wc", r), bus.win_clear, vt[r].wc);
        end

        // Legal commit mid-frame waits for the next vertical-blank edge
        for (int t = 0; t < FS; t++) cycle(0, 0, 0, 1, 4'(t), 6'd20, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("a_pend", bus.commit_pending, 1);
        chk("a_hold_coeffs", bus.coeffs, all_taps(23));
        for (int t = 0; t < 5; t++) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 3'b001, 0, 0, 0, 0, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0);
        chk("a_hold2_coeffs", bus.coeffs, all_taps(23));
        chk("a_hold2_sum", bus.coeff_sum, 253);
        cycle(0, 3'b010, 0, 0, 0, 0, 0);
        chk("a_xfer_coeffs", bus.coeffs, all_taps(20));
        chk("a_xfer_sum", bus.coeff_sum, 220);
        chk("a_xfer_pend", bus.commit_pending, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0);

        // Over-range commit is rejected; a later legal one still lands
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 4'd5, 6'd63, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("b_err", bus.cfg_err, 1);
        chk("b_pend", bus.commit_pending, 0);
        chk("b_coeffs", bus.coeffs, all_taps(23));
        cycle(0, 0, 0, 1, 4'd5, 6'd20, 1);
        chk("b_pend2", bus.commit_pending, 1);
        cycle(0, 3'b010, 0, 0, 0, 0, 0);
        e = all_taps(23);
        e[35:30] = 6'd20;
        chk("b_xfer_coeffs", bus.coeffs, e);
        chk("b_xfer_sum", bus.coeff_sum, 250);
        chk("b_err_sticky", bus.cfg_err, 1);
        cycle(0, 3'b000, 0, 0, 0, 0, 0);

        // Write, commit and vertical-blank edge all in one cycle
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 3'b010, 0, 1, 4'd0, 6'd1, 1);
        e = all_taps(23);
        e[5:0] = 6'd1;
        chk("c_coeffs", bus.coeffs, e);
        chk("c_sum", bus.coeff_sum, 231);
        chk("c_pend", bus.commit_pending, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0);

        // Reset mid-line discards the line and the pending commit
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("d_pend", bus.commit_pending, 1);
        cycle(0, 3'b001, 0, 0, 0, 0, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0);
        for (int t = 0; t < 7; t++) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        for (int t = 0; t < 15; t++) begin
            cycle(0, 0, 1, 0, 0, 0, 0);
            chk("d_px", bus.px_ok, 0);
        end
        chk("d_col", bus.col, 0);
        chk("d_line", bus.line, 0);
        chk("d_pend_clr", bus.commit_pending, 0);

        // Random traffic against the model
        rfvh = 3'b000;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) rfvh = 3'($urandom);
            rdata = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 28));
            cycle(($urandom_range(0, 599) == 0), rfvh, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 14) == 0), 4'($urandom), rdata,
                  ($urandom_range(0, 29) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
